// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ byte streams.
// A grant is held for a whole packet; each byte goes through the start/busy handshake.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int ID_W         = $clog2(NUM_REQ),
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 tx_start,
    output logic [7:0]           tx_data,
    input  logic                 tx_busy,
    output logic                 grant_valid,
    output logic [ID_W-1:0]      grant_id,
    output logic                 err_timeout,
    input  logic                 err_clr
);

    // state | meaning
    // IDLE  | no owner; pick next requester round-robin from ptr+1
    // SEND  | owner granted; accept one byte once transmitter is idle
    // ACK   | tx_start issued; wait for tx_busy to rise or time out
    // DONE  | wait for tx_busy to fall; release on last byte, else next byte
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        ACK  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [7:0]      TMO_LOAD = 8'(BUSY_TIMEOUT - 1);
    localparam logic [ID_W-1:0] PTR_RST  = ID_W'(NUM_REQ - 1);

    state_t          state, state_nxt;
    logic [ID_W-1:0] ptr, ptr_nxt;
    logic [ID_W-1:0] grant_id_nxt;
    logic            grant_valid_nxt;
    logic            tx_start_nxt;
    logic [7:0]      tx_data_nxt;
    logic            last_q, last_nxt;
    logic [7:0]      tmo_cnt, tmo_cnt_nxt;
    logic            tmo_hit;
    logic            err_nxt;

    logic            sel_valid;
    logic            sel_last;
    logic [7:0]      sel_data;
    logic            xfer;

    logic            hi_found;
    logic [ID_W-1:0] hi_id;
    logic [ID_W-1:0] lo_id;
    logic [ID_W-1:0] win_id;

    // Lowest requesting index above ptr wins; otherwise wrap to the lowest overall.
    always_comb begin
        hi_found = 1'b0;
        hi_id    = '0;
        lo_id    = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                lo_id = ID_W'(i);
                if (i > int'(ptr)) begin
                    hi_found = 1'b1;
                    hi_id    = ID_W'(i);
                end
            end
        end
        win_id = hi_found ? hi_id : lo_id;
    end

    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id == ID_W'(i)) begin
                sel_valid = req_valid[i];
                sel_last  = req_last[i];
                sel_data  = req_data[i*8 +: 8];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = (state == SEND) && (grant_id == ID_W'(i)) && !tx_busy;
        end
    end

    assign xfer = (state == SEND) && sel_valid && !tx_busy;

    always_comb begin
        state_nxt       = state;
        ptr_nxt         = ptr;
        grant_valid_nxt = grant_valid;
        grant_id_nxt    = grant_id;
        tx_start_nxt    = 1'b0;
        tx_data_nxt     = tx_data;
        last_nxt        = last_q;
        tmo_cnt_nxt     = tmo_cnt;
        tmo_hit         = 1'b0;

        case (state)
            IDLE: begin
                if (|req_valid) begin
                    grant_id_nxt    = win_id;
                    grant_valid_nxt = 1'b1;
                    state_nxt       = SEND;
                end
            end
            SEND: begin
                if (xfer) begin
                    tx_data_nxt  = sel_data;
                    tx_start_nxt = 1'b1;
                    last_nxt     = sel_last;
                    tmo_cnt_nxt  = TMO_LOAD;
                    state_nxt    = ACK;
                end
            end
            ACK: begin
                if (tx_busy) begin
                    state_nxt = DONE;
                end else if (tmo_cnt == 8'd0) begin
                    // Transmitter never answered; treat the byte as sent so the packet can finish.
                    tmo_hit   = 1'b1;
                    state_nxt = DONE;
                end else begin
                    tmo_cnt_nxt = tmo_cnt - 8'd1;
                end
            end
            DONE: begin
                if (!tx_busy) begin
                    if (last_q) begin
                        ptr_nxt         = grant_id;
                        grant_valid_nxt = 1'b0;
                        grant_id_nxt    = '0;
                        state_nxt       = IDLE;
                    end else begin
                        state_nxt = SEND;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        err_nxt = tmo_hit | (err_timeout & ~err_clr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ptr         <= PTR_RST;
            grant_valid <= 1'b0;
            grant_id    <= '0;
            tx_start    <= 1'b0;
            tx_data     <= '0;
            last_q      <= 1'b0;
            tmo_cnt     <= '0;
            err_timeout <= 1'b0;
        end else begin
            state       <= state_nxt;
            ptr         <= ptr_nxt;
            grant_valid <= grant_valid_nxt;
            grant_id    <= grant_id_nxt;
            tx_start    <= tx_start_nxt;
            tx_data     <= tx_data_nxt;
            last_q      <= last_nxt;
            tmo_cnt     <= tmo_cnt_nxt;
            err_timeout <= err_nxt;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: queued packet requesters, a serialising UART model and
// a packet-level round-robin reference for the expected byte/grant order.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

    localparam int NUM_REQ      = 4;
    localparam int ID_W         = 2;
    localparam int BUSY_TIMEOUT = 16;
    localparam int BIT_CYC      = 2;
    localparam int QDEPTH       = 64;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [NUM_REQ-1:0]   req_valid = '0;
    logic [8*NUM_REQ-1:0] req_data = '0;
    logic [NUM_REQ-1:0]   req_last = '0;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 tx_start;
    logic [7:0]           tx_data;
    logic                 tx_busy;
    logic                 grant_valid;
    logic [ID_W-1:0]      grant_id;
    logic                 err_timeout;
    logic                 err_clr = 1'b0;

    uart_tx_arbiter #(
        .NUM_REQ(NUM_REQ), .ID_W(ID_W), .BUSY_TIMEOUT(BUSY_TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
        .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
        .grant_valid(grant_valid), .grant_id(grant_id),
        .err_timeout(err_timeout), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // UART model: busy from the edge after tx_start for 10 bit times; the line bit is taken
    // from the live tx_data, so a byte changing mid-frame shows up in the captured frame.
    logic bfm_busy = 1'b0;
    logic bfm_en = 1'b1;
    logic busy_force = 1'b0;
    int   bfm_bit = 0;
    int   bfm_sub = 0;
    logic frame_q[$];
    logic [9:0] frame_w;
    logic [9:0] frame_sh;
    assign tx_busy = bfm_busy | busy_force;

    always @(posedge clk) begin
        if (bfm_busy) begin
            if (bfm_sub == BIT_CYC - 1) begin
                frame_w  = {1'b1, tx_data, 1'b0};
                frame_sh = frame_w >> bfm_bit;
                frame_q.push_back(frame_sh[0]);
                bfm_sub <= 0;
                bfm_bit <= bfm_bit + 1;
                if (bfm_bit == 9) bfm_busy <= 1'b0;
            end else begin
                bfm_sub <= bfm_sub + 1;
            end
        end else if (tx_start && bfm_en) begin
            bfm_busy <= 1'b1;
            bfm_bit  <= 0;
            bfm_sub  <= 0;
        end
    end

    // Passive monitor.
    logic [7:0] log_data[$];
    int         log_id[$];
    int         log_cyc[$];
    int         grant_log[$];
    int         grant_cyc[$];
    int         err_cyc[$];
    int         ready_viol = 0;
    logic       prev_gv = 1'b0;
    logic       prev_err = 1'b0;

    always @(negedge clk) begin
        if (tx_start) begin
            log_data.push_back(tx_data);
            log_id.push_back(int'(grant_id));
            log_cyc.push_back(cyc);
        end
        if (grant_valid && !prev_gv) begin
            grant_log.push_back(int'(grant_id));
            grant_cyc.push_back(cyc);
        end
        if (err_timeout && !prev_err) err_cyc.push_back(cyc);
        if (req_ready != '0 &&
            (tx_busy || !grant_valid || req_ready != (NUM_REQ'(1) << grant_id)))
            ready_viol++;
        prev_gv  = grant_valid;
        prev_err = err_timeout;
    end

    // Requester packet stores and reference expectations.
    logic [7:0] pd[NUM_REQ][QDEPTH];
    logic       pl[NUM_REQ][QDEPTH];
    int         hd[NUM_REQ];
    int         tl[NUM_REQ];
    logic       gap_en = 1'b0;
    int         m_ptr = NUM_REQ - 1;
    int         drive_cyc = 0;
    int         rel_cyc = 0;
    logic [7:0] exp_data[$];
    int         exp_id[$];
    int         exp_grants[$];

    task automatic clear_reqs();
        for (int i = 0; i < NUM_REQ; i++) begin
            hd[i] = 0;
            tl[i] = 0;
        end
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
    endtask

    task automatic add_byte(input int r, input logic [7:0] d, input logic l);
        pd[r][tl[r]] = d;
        pl[r][tl[r]] = l;
        tl[r]++;
    endtask

    // Whole packets rotate among requesters that still have data, starting after m_ptr.
    task automatic build_expect();
        int   cur[NUM_REQ];
        int   sel;
        bit   any;
        logic lastb;
        exp_data.delete();
        exp_id.delete();
        exp_grants.delete();
        for (int i = 0; i < NUM_REQ; i++) cur[i] = hd[i];
        for (int g = 0; g < 256; g++) begin
            any = 0;
            sel = 0;
            for (int k = 1; k <= NUM_REQ; k++) begin
                if (!any && cur[(m_ptr + k) % NUM_REQ] != tl[(m_ptr + k) % NUM_REQ]) begin
                    any = 1;
                    sel = (m_ptr + k) % NUM_REQ;
                end
            end
            if (!any) break;
            exp_grants.push_back(sel);
            lastb = 1'b0;
            while (!lastb && cur[sel] != tl[sel]) begin
                exp_data.push_back(pd[sel][cur[sel]]);
                exp_id.push_back(sel);
                lastb = pl[sel][cur[sel]];
                cur[sel]++;
            end
            m_ptr = sel;
        end
    endtask

    task automatic drive_reqs();
        bit first;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (hd[i] == tl[i]) begin
                req_valid[i]       = 1'b0;
                req_last[i]        = 1'b0;
                req_data[i*8 +: 8] = 8'h00;
            end else begin
                first = (hd[i] == 0) || pl[i][hd[i] - 1];
                req_valid[i]       = first || !gap_en || ($urandom_range(3) != 0);
                req_last[i]        = pl[i][hd[i]];
                req_data[i*8 +: 8] = pd[i][hd[i]];
            end
        end
    endtask

    function automatic bit all_empty();
        bit e = 1;
        for (int i = 0; i < NUM_REQ; i++) if (hd[i] != tl[i]) e = 0;
        return e;
    endfunction

    task automatic run_traffic(input string name, input int max_cyc, input int busy_hold);
        logic [NUM_REQ-1:0] taken;
        int n;
        bit done;
        taken = '0;
        n = 0;
        done = 0;
        while (!done && n < max_cyc) begin
            @(negedge clk);
            for (int i = 0; i < NUM_REQ; i++) if (taken[i]) hd[i]++;
            drive_reqs();
            if (n == 0) drive_cyc = cyc;
            if (n == busy_hold) begin
                busy_force = 1'b0;
                rel_cyc = cyc;
            end
            #1;
            taken = req_valid & req_ready;
            n++;
            done = all_empty() && !grant_valid && (taken == '0);
        end
        n_cmp++;
        if (!done) begin
            n_fail++;
            $display("FAIL %s drain: still busy after %0d cycles, required to drain within %0d", name, n, max_cyc);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_reqs();
        repeat (3) @(negedge clk);
        n_cmp++; if (grant_valid !== 1'b0) begin n_fail++; $display("FAIL reset grant_valid: got %b, required 0", grant_valid); end
        n_cmp++; if (grant_id !== '0) begin n_fail++; $display("FAIL reset grant_id: got %0d, required 0", grant_id); end
        n_cmp++; if (tx_start !== 1'b0) begin n_fail++; $display("FAIL reset tx_start: got %b, required 0", tx_start); end
        n_cmp++; if (tx_data !== 8'h00) begin n_fail++; $display("FAIL reset tx_data: got %02h, required 00", tx_data); end
        n_cmp++; if (err_timeout !== 1'b0) begin n_fail++; $display("FAIL reset err_timeout: got %b, required 0", err_timeout); end
        n_cmp++; if (req_ready !== '0) begin n_fail++; $display("FAIL reset req_ready: got %b, required 0000", req_ready); end
        rst_n = 1'b1;
        m_ptr = NUM_REQ - 1;
        repeat (2) @(negedge clk);
        n_cmp++; if (grant_valid !== 1'b0) begin n_fail++; $display("FAIL reset idle grant_valid: got %b, required 0", grant_valid); end
    endtask

    task automatic test_single_byte();
        int lb = log_data.size();
        int gb = grant_log.size();
        int fb = frame_q.size();
        int rv = ready_viol;
        logic [9:0] got_frame;
        clear_reqs();
        gap_en = 1'b0;
        add_byte(0, 8'h56, 1'b1);
        build_expect();
        run_traffic("single", 400, 0);
        n_cmp++;
        if (grant_log.size() != gb + 1 || log_data.size() != lb + 1) begin
            n_fail++;
            $display("FAIL single counts: got %0d grants %0d starts, required 1 and 1", grant_log.size() - gb, log_data.size() - lb);
        end else begin
            n_cmp++; if (grant_log[gb] != 0) begin n_fail++; $display("FAIL single grant_id: got %0d, required 0", grant_log[gb]); end
            n_cmp++; if (grant_cyc[gb] - drive_cyc != 1) begin n_fail++; $display("FAIL single grant latency: got %0d, required 1", grant_cyc[gb] - drive_cyc); end
            n_cmp++; if (log_cyc[lb] - drive_cyc != 2) begin n_fail++; $display("FAIL single start latency: got %0d, required 2", log_cyc[lb] - drive_cyc); end
            n_cmp++; if (log_data[lb] !== 8'h56) begin n_fail++; $display("FAIL single tx_data: got %02h, required 56", log_data[lb]); end
        end
        got_frame = '0;
        n_cmp++;
        if (frame_q.size() != fb + 10) begin
            n_fail++;
            $display("FAIL single frame length: got %0d bits, required 10", frame_q.size() - fb);
        end else begin
            for (int k = 0; k < 10; k++) got_frame[k] = frame_q[fb + k];
            n_cmp++;
            if (got_frame !== 10'h2AC) begin n_fail++; $display("FAIL single serial frame: got %b, required %b (LSB first)", got_frame, 10'h2AC); end
        end
        n_cmp++; if (grant_valid !== 1'b0) begin n_fail++; $display("FAIL single release: grant_valid got %b, required 0", grant_valid); end
        n_cmp++; if (ready_viol != rv) begin n_fail++; $display("FAIL single ready rule: got %0d violations, required 0", ready_viol - rv); end
    endtask

    task automatic test_two_req();
        int lb = log_data.size();
        int gb = grant_log.size();
        clear_reqs();
        add_byte(1, 8'h93, 1'b1);
        add_byte(2, 8'hA5, 1'b1);
        build_expect();
        run_traffic("two_req", 600, 0);
        n_cmp++;
        if (log_data.size() - lb != 2 || exp_data.size() != 2) begin
            n_fail++;
            $display("FAIL two_req count: got %0d bytes, required 2", log_data.size() - lb);
        end else begin
            for (int k = 0; k < 2; k++) begin
                n_cmp++;
                if (log_data[lb + k] !== exp_data[k] || log_id[lb + k] != exp_id[k]) begin
                    n_fail++;
                    $display("FAIL two_req byte %0d: got %02h/id%0d, required %02h/id%0d", k, log_data[lb + k], log_id[lb + k], exp_data[k], exp_id[k]);
                end
            end
            n_cmp++; if (log_data[lb] !== 8'h93) begin n_fail++; $display("FAIL two_req first: got %02h, required 93", log_data[lb]); end
        end
        n_cmp++;
        if (grant_log.size() - gb != 2 || grant_log[gb + grant_log.size() - gb - 1] != 2) begin
            n_fail++;
            $display("FAIL two_req final grant: got %0d grants, required 2 ending at 2", grant_log.size() - gb);
        end
    endtask

    task automatic test_packet_lock();
        int lb = log_data.size();
        int gb = grant_log.size();
        int rv = ready_viol;
        clear_reqs();
        gap_en = 1'b1;
        add_byte(0, 8'h11, 1'b0);
        add_byte(0, 8'h22, 1'b0);
        add_byte(0, 8'h33, 1'b1);
        add_byte(1, 8'h44, 1'b1);
        build_expect();
        run_traffic("packet_lock", 1000, 0);
        gap_en = 1'b0;
        n_cmp++;
        if (log_data.size() - lb != exp_data.size()) begin
            n_fail++;
            $display("FAIL lock count: got %0d bytes, required %0d", log_data.size() - lb, exp_data.size());
        end else begin
            for (int k = 0; k < exp_data.size(); k++) begin
                n_cmp++;
                if (log_data[lb + k] !== exp_data[k] || log_id[lb + k] != exp_id[k]) begin
                    n_fail++;
                    $display("FAIL lock byte %0d: got %02h/id%0d, required %02h/id%0d", k, log_data[lb + k], log_id[lb + k], exp_data[k], exp_id[k]);
                end
            end
        end
        n_cmp++; if (grant_log.size() - gb != 2) begin n_fail++; $display("FAIL lock grants: got %0d, required 2", grant_log.size() - gb); end
        n_cmp++; if (ready_viol != rv) begin n_fail++; $display("FAIL lock ready rule: got %0d violations, required 0", ready_viol - rv); end
    endtask

    task automatic test_timeout();
        int lb = log_data.size();
        int eb = err_cyc.size();
        clear_reqs();
        bfm_en = 1'b0;
        add_byte(0, 8'h7E, 1'b1);
        build_expect();
        run_traffic("timeout", 500, 0);
        n_cmp++;
        if (err_cyc.size() != eb + 1 || log_data.size() != lb + 1) begin
            n_fail++;
            $display("FAIL timeout events: got %0d errors %0d starts, required 1 and 1", err_cyc.size() - eb, log_data.size() - lb);
        end else begin
            n_cmp++; if (err_cyc[eb] - log_cyc[lb] != BUSY_TIMEOUT) begin n_fail++; $display("FAIL timeout latency: got %0d, required %0d", err_cyc[eb] - log_cyc[lb], BUSY_TIMEOUT); end
            n_cmp++; if (log_data[lb] !== 8'h7E) begin n_fail++; $display("FAIL timeout tx_data: got %02h, required 7E", log_data[lb]); end
        end
        n_cmp++; if (err_timeout !== 1'b1) begin n_fail++; $display("FAIL timeout sticky: got %b, required 1", err_timeout); end
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        n_cmp++; if (err_timeout !== 1'b0) begin n_fail++; $display("FAIL timeout clear: got %b, required 0", err_timeout); end

        err_clr = 1'b1;
        add_byte(0, 8'h81, 1'b1);
        build_expect();
        run_traffic("timeout_set_wins", 500, 0);
        n_cmp++;
        if (err_cyc.size() != eb + 2 || log_data.size() != lb + 2) begin
            n_fail++;
            $display("FAIL set_wins events: got %0d errors %0d starts, required 2 and 2", err_cyc.size() - eb, log_data.size() - lb);
        end else begin
            n_cmp++; if (err_cyc[eb + 1] - log_cyc[lb + 1] != BUSY_TIMEOUT) begin n_fail++; $display("FAIL set_wins latency: got %0d, required %0d", err_cyc[eb + 1] - log_cyc[lb + 1], BUSY_TIMEOUT); end
        end
        n_cmp++; if (err_timeout !== 1'b0) begin n_fail++; $display("FAIL set_wins cleared after: got %b, required 0", err_timeout); end
        err_clr = 1'b0;
        bfm_en  = 1'b1;
    endtask

    task automatic test_round_robin();
        int lb, gb;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        m_ptr = NUM_REQ - 1;
        lb = log_data.size();
        gb = grant_log.size();
        clear_reqs();
        for (int p = 0; p < 2; p++)
            for (int r = 0; r < NUM_REQ; r++) add_byte(r, 8'(8'hD0 + 16 * p + r), 1'b1);
        build_expect();
        run_traffic("round_robin", 2000, 0);
        n_cmp++;
        if (grant_log.size() - gb != exp_grants.size() || log_data.size() - lb != exp_grants.size()) begin
            n_fail++;
            $display("FAIL rr counts: got %0d grants %0d starts, required %0d each", grant_log.size() - gb, log_data.size() - lb, exp_grants.size());
        end else begin
            for (int k = 0; k < exp_grants.size(); k++) begin
                n_cmp++;
                if (grant_log[gb + k] != exp_grants[k] || grant_log[gb + k] != k % NUM_REQ || log_data[lb + k] !== exp_data[k]) begin
                    n_fail++;
                    $display("FAIL rr grant %0d: got id%0d/%02h, required id%0d/%02h", k, grant_log[gb + k], log_data[lb + k], exp_grants[k], exp_data[k]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [NUM_REQ-1:0] taken;
        int  lb, gb, rv;
        bit  seen;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m_ptr = NUM_REQ - 1;
        clear_reqs();
        add_byte(2, 8'hB2, 1'b0);
        add_byte(2, 8'hB3, 1'b1);
        taken = '0;
        seen = 0;
        for (int n = 0; n < 200 && !seen; n++) begin
            @(negedge clk);
            for (int i = 0; i < NUM_REQ; i++) if (taken[i]) hd[i]++;
            drive_reqs();
            if (tx_start) seen = 1;
            #1;
            taken = req_valid & req_ready;
        end
        n_cmp++;
        if (!seen) begin
            n_fail++;
            $display("FAIL reset_mid start: got no tx_start within 200 cycles, required one");
        end
        rst_n = 1'b0;
        busy_force = 1'b1;
        clear_reqs();
        #1;
        n_cmp++; if (grant_valid !== 1'b0) begin n_fail++; $display("FAIL reset_mid grant_valid: got %b, required 0", grant_valid); end
        n_cmp++; if (tx_start !== 1'b0) begin n_fail++; $display("FAIL reset_mid tx_start: got %b, required 0", tx_start); end
        @(negedge clk);
        rst_n = 1'b1;
        m_ptr = NUM_REQ - 1;
        lb = log_data.size();
        gb = grant_log.size();
        rv = ready_viol;
        add_byte(1, 8'hC1, 1'b1);
        add_byte(3, 8'hC3, 1'b1);
        build_expect();
        run_traffic("reset_mid", 800, 8);
        n_cmp++;
        if (grant_log.size() - gb != 2 || log_data.size() - lb != 2) begin
            n_fail++;
            $display("FAIL reset_mid counts: got %0d grants %0d starts, required 2 and 2", grant_log.size() - gb, log_data.size() - lb);
        end else begin
            n_cmp++; if (grant_log[gb] != 1 || grant_log[gb] != exp_grants[0]) begin n_fail++; $display("FAIL reset_mid first grant: got %0d, required 1", grant_log[gb]); end
            n_cmp++; if (log_data[lb] !== exp_data[0] || log_data[lb + 1] !== exp_data[1]) begin n_fail++; $display("FAIL reset_mid order: got %02h %02h, required %02h %02h", log_data[lb], log_data[lb + 1], exp_data[0], exp_data[1]); end
            n_cmp++; if (log_cyc[lb] <= rel_cyc) begin n_fail++; $display("FAIL reset_mid busy hold: start at %0d, required after %0d", log_cyc[lb], rel_cyc); end
        end
        n_cmp++; if (ready_viol != rv) begin n_fail++; $display("FAIL reset_mid ready rule: got %0d violations, required 0", ready_viol - rv); end
    endtask

    task automatic test_random();
        int lb, npk, len, tot;
        for (int round = 0; round < 4; round++) begin
            lb = log_data.size();
            clear_reqs();
            gap_en = 1'b1;
            tot = 0;
            for (int r = 0; r < NUM_REQ; r++) begin
                npk = $urandom_range(2);
                for (int p = 0; p < npk; p++) begin
                    len = $urandom_range(4, 1);
                    for (int b = 0; b < len; b++) add_byte(r, 8'($urandom), b == len - 1);
                    tot++;
                end
            end
            if (tot == 0) add_byte($urandom_range(NUM_REQ - 1), 8'($urandom), 1'b1);
            build_expect();
            run_traffic("random", 3000, 0);
            n_cmp++;
            if (log_data.size() - lb != exp_data.size()) begin
                n_fail++;
                $display("FAIL random round %0d count: got %0d bytes, required %0d", round, log_data.size() - lb, exp_data.size());
            end else begin
                for (int k = 0; k < exp_data.size(); k++) begin
                    n_cmp++;
                    if (log_data[lb + k] !== exp_data[k] || log_id[lb + k] != exp_id[k]) begin
                        n_fail++;
                        $display("FAIL random round %0d byte %0d: got %02h/id%0d, required %02h/id%0d", round, k, log_data[lb + k], log_id[lb + k], exp_data[k], exp_id[k]);
                    end
                end
            end
        end
        gap_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_two_req();
        test_packet_lock();
        test_timeout();
        test_round_robin();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART transmitter inside uart_top between NUM_REQ byte-stream requesters.
- Uses round-robin arbitration with packet lock: a granted requester keeps the transmitter until it sends a byte flagged last.
- Sequences each byte through the transmitter's start/busy handshake and flags a transmitter that never acknowledges.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..8.
- ID_W, $clog2(NUM_REQ), width of grant_id.
- BUSY_TIMEOUT, 16, clock cycles allowed between tx_start and tx_busy rising; legal range 1..255.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  requester i has a byte on req_data[i*8+:8].
- req_data  in  8*NUM_REQ  byte per requester.
- req_last  in  NUM_REQ  byte is the final byte of requester i's packet.
- req_ready  out  NUM_REQ  byte accepted from requester i this cycle (valid & ready).
- tx_start  out  1  one-cycle pulse that starts the UART transmitter.
- tx_data  out  8  byte to transmit; stable from the tx_start cycle until tx_busy falls.
- tx_busy  in  1  transmitter busy, from the start bit through the stop bit.
- grant_valid  out  1  a requester currently owns the transmitter.
- grant_id  out  ID_W  index of the owner; 0 when grant_valid=0.
- err_timeout  out  1  sticky: tx_busy did not rise within BUSY_TIMEOUT.
- err_clr  in  1  clears err_timeout.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE; tx_start=0, tx_data=0, grant_valid=0, grant_id=0, err_timeout=0.
  - Round-robin pointer=NUM_REQ-1, so requester 0 has first priority. Counters=0.
- Output timing:
  - req_ready is combinational: req_ready[i] = (state==SEND) && grant_id==i && !tx_busy.
  - All other outputs are registered.
- States: IDLE, SEND, ACK, DONE.
- IDLE:
  - If any req_valid is set, pick the first set bit searching from pointer+1, wrapping modulo NUM_REQ.
  - Next cycle: grant_id=winner, grant_valid=1, state=SEND.
  - Requests are sampled only in IDLE; a request rising later waits.
- SEND:
  - Transfer happens when req_valid[g] & req_ready[g].
  - On transfer: tx_data<=req_data[g]; tx_start<=1 for exactly the next cycle; last_q<=req_last[g]; timeout counter cleared; state=ACK.
  - If req_valid[g]=0: hold in SEND with the grant kept (packet lock). Other requesters wait indefinitely.
- ACK:
  - tx_busy=1: go to DONE.
  - Otherwise the counter increments each cycle. When it reaches BUSY_TIMEOUT: err_timeout<=1 and go to DONE, treating the byte as sent.
- DONE: wait for tx_busy=0, then:
  - last_q=1: pointer<=grant_id; grant_valid<=0; grant_id<=0; state=IDLE.
  - last_q=0: state=SEND with the same grantee.
- Latency:
  - Request valid at cycle 0 in IDLE gives grant_valid=1 at cycle 1, req_ready at cycle 1 (tx_busy low), and tx_start at cycle 2.
  - Back-to-back bytes of one packet: next req_ready comes in the cycle after DONE sees tx_busy=0.
- Errors:
  - err_timeout is set by a timeout and cleared by err_clr. If both occur in the same cycle, set wins.
  - err_timeout does not block operation.
- Wrap-around: the pointer rotates modulo NUM_REQ. With all requesters continuously requesting, grants rotate 0,1,2,...,NUM_REQ-1,0.
- Reset mid-operation:
  - All state is discarded; the pointer returns to NUM_REQ-1.
  - A byte already handed to the transmitter is not retracted; the arbiter does not track it.
  - After reset the arbiter waits in IDLE regardless of tx_busy. SEND does not accept a byte until tx_busy=0.
- tx_busy already high when SEND is entered: no acceptance until it falls.
- Simultaneous req_valid and req_last on a single-byte packet: the grant is released after that byte.

Test Plan:
- Reset, then req_valid[0]=1, data 0x56, last=1 → grant_id=0 at +1 cycle, tx_start pulse at +2 with tx_data=0x56. Serial line carries 0,0,1,1,0,1,0,1,0,1 (start, LSB first, stop). grant_valid=0 after tx_busy falls.
- req_valid[1] and req_valid[2] asserted in the same cycle, single-byte packets 0x93 and 0xA5 → 0x93 sent first via grant 1, then 0xA5 via grant 2; pointer ends at 2.
- req0 sends a 3-byte packet 0x11,0x22,0x33 (last on 0x33) while req1 holds 0x44 → tx_data order 0x11,0x22,0x33,0x44. grant_id stays 0 for all three bytes; req_ready[1]=0 throughout.
- tx_busy tied low, req0 byte 0x7E → err_timeout=1 exactly BUSY_TIMEOUT cycles after tx_start. Arbiter returns to IDLE; err_clr drops err_timeout next cycle.
- All four requesters request continuously with single-byte packets → grant order 0,1,2,3,0,1; each grant is followed by exactly one tx_start.
- rst_n pulsed low during ACK of a packet from requester 2 → grant_valid=0 and tx_start=0 immediately. The next request from 1 and 3 together grants 1 (pointer reset).
